jls_frame_sequencer: RTL

//  Frame-level controller in front of jls_encoder. Accepts frame commands (width/height) and a

---
 rtl/jls_seq_pkg.sv | 21 ++
 rtl/jls_frame_sequencer_if.sv | 33 +++
 rtl/jls_seq_raster_cnt.sv | 38 +++
 rtl/jls_frame_sequencer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/jls_seq_pkg.sv
// rtl/jls_seq_pkg.sv - shared state type, size limits and counter widths for the JPEG-LS frame sequencer
package jls_seq_pkg;

  typedef enum logic [2:0] {IDLE, SOF, PIX, GAP, DRAIN} seq_state_t;

  localparam int CMD_W_BITS = 15;
  localparam int CMD_H_BITS = 14;
  localparam int DIM_BITS   = 14;

  localparam logic [CMD_W_BITS-1:0] MIN_W = 15'd5;
  localparam logic [CMD_W_BITS-1:0] MAX_W = 15'd16384;
  localparam logic [CMD_H_BITS-1:0] MIN_H = 14'd1;
  localparam logic [CMD_H_BITS-1:0] MAX_H = 14'd16383;

  // MAX_H is the largest value cmd_h can carry, so only the lower bound needs a compare.
  function automatic logic size_legal(input logic [CMD_W_BITS-1:0] w,
                                      input logic [CMD_H_BITS-1:0] h);
    return (w >= MIN_W) && (w <= MAX_W) && (h >= MIN_H);
  endfunction

endpackage

// File: rtl/jls_frame_sequencer_if.sv
// rtl/jls_frame_sequencer_if.sv - command, pixel stream and encoder-side signals of the frame sequencer
interface jls_frame_sequencer_if;
  import jls_seq_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_W_BITS-1:0] cmd_w;
  logic [CMD_H_BITS-1:0] cmd_h;
  logic                  cmd_err;
  logic                  s_valid;
  logic                  s_ready;
  logic [7:0]            s_data;
  logic                  enc_sof;
  logic [DIM_BITS-1:0]   enc_w;
  logic [DIM_BITS-1:0]   enc_h;
  logic                  enc_e;
  logic [7:0]            enc_x;
  logic                  enc_o_e;
  logic                  enc_o_last;
  logic                  busy;
  logic                  frame_done;

  modport slave (
    input  cmd_valid, cmd_w, cmd_h, s_valid, s_data, enc_o_e, enc_o_last,
    output cmd_ready, cmd_err, s_ready, enc_sof, enc_w, enc_h, enc_e, enc_x, busy, frame_done
  );

  modport master (
    output cmd_valid, cmd_w, cmd_h, s_valid, s_data, enc_o_e, enc_o_last,
    input  cmd_ready, cmd_err, s_ready, enc_sof, enc_w, enc_h, enc_e, enc_x, busy, frame_done
  );

endinterface

// File: rtl/jls_seq_raster_cnt.sv
// rtl/jls_seq_raster_cnt.sv - column/row raster position counter; last flags the final pixel of the frame
module jls_seq_raster_cnt
  import jls_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic [DIM_BITS-1:0] w_m1,
  input  logic [DIM_BITS-1:0] h_m1,
  output logic                last
);

  logic [DIM_BITS-1:0] col;
  logic [DIM_BITS-1:0] row;
  logic                col_wrap;

  assign col_wrap = (col == w_m1);
  assign last     = col_wrap && (row == h_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
    end else if (step) begin
      if (col_wrap) begin
        col <= '0;
        row <= row + 14'd1;
      end else begin
        col <= col + 14'd1;
      end
    end
  end

endmodule

// File: rtl/jls_frame_sequencer.sv
// rtl/jls_frame_sequencer.sv - frame sequencer feeding jls_encoder; JLS_SEQ_STATS_EN adds frame/word statistics outputs
module jls_frame_sequencer
  import jls_seq_pkg::*;
#(
  parameter int SOF_CYCLES = 368,
  parameter int GAP_CYCLES = 16,
  parameter bit WAIT_LAST  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  jls_frame_sequencer_if.slave bus
`ifdef JLS_SEQ_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [31:0] stat_words
`endif
);

  localparam int SOF_CW = (SOF_CYCLES > 1) ? $clog2(SOF_CYCLES) : 1;
  localparam int GAP_CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SOF_CW-1:0] SOF_LOAD = SOF_CW'(SOF_CYCLES - 1);
  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_t          state;
  seq_state_t          state_n;
  logic [SOF_CW-1:0]   sof_cnt;
  logic [GAP_CW-1:0]   gap_cnt;
  logic [DIM_BITS-1:0] w_m1;
  logic [DIM_BITS-1:0] h_m1;
  logic                cmd_hs;
  logic                cmd_ok;
  logic                sof_enter;
  logic                pix_hs;
  logic                pix_last;
  logic                frame_end;
  logic                last_seen;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.s_ready   = (state == PIX);
  assign bus.busy      = (state != IDLE);

  assign cmd_hs    = bus.cmd_valid && bus.cmd_ready;
  assign cmd_ok    = size_legal(bus.cmd_w, bus.cmd_h);
  assign sof_enter = cmd_hs && cmd_ok;
  assign pix_hs    = bus.s_valid && bus.s_ready;
  assign frame_end = bus.enc_o_e && bus.enc_o_last;

  jls_seq_raster_cnt u_raster (
    .clk  (clk),
    .rst  (rst),
    .load (sof_enter),
    .step (pix_hs),
    .w_m1 (w_m1),
    .h_m1 (h_m1),
    .last (pix_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (sof_enter) state_n = SOF;
      SOF:     if (sof_cnt == '0) state_n = PIX;
      PIX: begin
        if (pix_hs && pix_last) begin
          if (GAP_CYCLES > 0) state_n = GAP;
          else                state_n = WAIT_LAST ? DRAIN : IDLE;
        end
      end
      GAP:     if (gap_cnt == '0) state_n = WAIT_LAST ? DRAIN : IDLE;
      DRAIN:   if (last_seen || frame_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // last_seen keeps an o_last that lands before DRAIN from being missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sof_cnt   <= '0;
      gap_cnt   <= '0;
      w_m1      <= '0;
      h_m1      <= '0;
      last_seen <= 1'b0;
    end else begin
      if (sof_enter) begin
        sof_cnt <= SOF_LOAD;
        w_m1    <= DIM_BITS'(bus.cmd_w - 15'd1);
        h_m1    <= bus.cmd_h - 14'd1;
      end else if (state == SOF && sof_cnt != '0) begin
        sof_cnt <= sof_cnt - SOF_CW'(1);
      end

      if (state == PIX) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_CW'(1);
      end

      if (sof_enter) begin
        last_seen <= 1'b0;
      end else if (frame_end) begin
        last_seen <= 1'b1;
      end
    end
  end

  // Encoder drive is registered from the current state, so it trails the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.enc_sof    <= 1'b0;
      bus.enc_w      <= '0;
      bus.enc_h      <= '0;
      bus.enc_e      <= 1'b0;
      bus.enc_x      <= '0;
      bus.cmd_err    <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.enc_sof    <= (state == SOF);
      bus.enc_w      <= (state == SOF) ? w_m1 : '0;
      bus.enc_h      <= (state == SOF) ? h_m1 : '0;
      bus.enc_e      <= pix_hs;
      bus.enc_x      <= pix_hs ? bus.s_data : '0;
      bus.cmd_err    <= cmd_hs && !cmd_ok;
      bus.frame_done <= frame_end;
    end
  end

`ifdef JLS_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_frames <= '0;
      stat_words  <= '0;
    end else begin
      if (frame_end) begin
        stat_frames <= stat_frames + 16'd1;
      end
      if (bus.enc_o_e && stat_words != '1) begin
        stat_words <= stat_words + 32'd1;
      end
    end
  end
`endif

endmodule
